// File: rtl/alu_operand_stage.sv
// Operand fetch / writeback stage wrapped around an external combinational ALU.
// EX registers feed the ALU; WB registers capture its result and update the register file.
module alu_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_rs1,
  input  logic [IDX_W-1:0]  req_rs2,
  input  logic [IDX_W-1:0]  req_rd,
  input  logic [3:0]        req_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              wb_valid,
  output logic [IDX_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              carry_flag
);

  logic [DATA_W-1:0] regs [NREGS];
  logic              ex_valid;
  logic [IDX_W-1:0]  ex_rd;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              accept;

  assign req_ready = !stall;
  assign accept    = req_valid && !stall;

  // The op in EX is younger than anything in the register file, so its result wins.
  always_comb begin
    op_a = regs[req_rs1];
    if (req_rs1 == '0)
      op_a = '0;
    else if (ex_valid && (ex_rd == req_rs1))
      op_a = alu_result;
  end

  always_comb begin
    op_b = regs[req_rs2];
    if (req_rs2 == '0)
      op_b = '0;
    else if (ex_valid && (ex_rd == req_rs2))
      op_b = alu_result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs       <= '{default: '0};
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      carry_flag <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        alu_a    <= op_a;
        alu_b    <= op_b;
        alu_sel  <= req_sel;
        ex_rd    <= req_rd;
        ex_valid <= 1'b1;
      end else begin
        ex_valid <= 1'b0;
      end

      // Writes to r0 are dropped but still produce a visible writeback pulse.
      if (ex_valid) begin
        if (ex_rd != '0)
          regs[ex_rd] <= alu_result;
        wb_rd      <= ex_rd;
        wb_data    <= alu_result;
        carry_flag <= alu_carry;
        wb_valid   <= 1'b1;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, ALU operand/result width; NREGS, default 16, register count; IDX_W, default 4, register index width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 stall  input  1  freeze whole stage while high.
REQ-005 req_valid  input  1  operation request present.
REQ-006 req_ready  output  1  stage can accept a request.
REQ-007 req_rs1, req_rs2, req_rd  input  IDX_W each  source/destination register indices.
REQ-008 req_sel  input  4  ALU operation select (0000 add, 0001 sub, 0010 mul, 0011 div).
REQ-009 alu_a, alu_b  output  DATA_W each  registered operands to ALU.
REQ-010 alu_sel  output  4  registered operation select to ALU.
REQ-011 alu_result  input  DATA_W  ALU combinational result.
REQ-012 alu_carry  input  1  ALU carry-out.
REQ-013 wb_valid  output  1  one-cycle pulse: writeback occurred.
REQ-014 wb_rd  output  IDX_W; wb_data  output  DATA_W  last written index/value.
REQ-015 carry_flag  output  1  carry of last completed operation.

Function
REQ-016 Stage SHALL hold NREGS x DATA_W register file; register 0 SHALL read as 0 and ignore writes.
REQ-017 req_ready SHALL equal !stall; request accepted on edge where req_valid && req_ready.
REQ-018 Pipeline: EX stage (ex_valid, ex_rd, alu_a, alu_b, alu_sel) and WB stage (wb_valid, wb_rd, wb_data, carry_flag).
REQ-019 Accept in cycle N: alu_a/alu_b/alu_sel/ex_valid load at end of N; ALU evaluates in N+1; result written at end of N+1; wb_valid high in N+2 (latency 2 cycles accept-to-wb_valid).
REQ-020 Operand read SHALL forward alu_result when ex_valid && ex_rd==rs && rs!=0 (back-to-back dependence, zero bubbles).
REQ-021 Writes at end of N+1 SHALL be visible to a request accepted in N+2 via the register file (no extra path needed).
REQ-022 Non-accept, non-stalled cycle: ex_valid clears to 0; alu_a/alu_b/alu_sel retain values.
REQ-023 WB edge with ex_valid=1: regfile[ex_rd]<=alu_result (unless ex_rd==0), wb_rd<=ex_rd, wb_data<=alu_result, carry_flag<=alu_carry, wb_valid<=1; otherwise wb_valid<=0, other WB registers hold.
REQ-024 ex_rd==0 SHALL still pulse wb_valid and update carry_flag, wb_data = alu_result.
REQ-025 stall high: no state changes at all (EX, WB, regfile, wb_valid holds its value); alu_result must be held stable by ALU since operands frozen.
REQ-026 Two consecutive writes to same rd: later value wins; forwarding always selects youngest (EX) over regfile.
REQ-027 Arithmetic: values passed unmodified at DATA_W bits; no sign extension or truncation in this stage.

Reset
REQ-028 rst_n low SHALL immediately clear all registers (regfile, alu_a, alu_b, alu_sel, ex_valid, ex_rd, wb_valid, wb_rd, wb_data, carry_flag) to 0, independent of clk.
REQ-029 Reset mid-operation SHALL discard any in-flight EX op (no writeback after release).
REQ-030 First request SHALL be accepted on the first rising edge with rst_n high and stall low.

Verification
REQ-031 After reset, request rs1=0, rs2=0, rd=3, sel=0000, ALU model adds -> alu_a=alu_b=0 next cycle, wb_valid pulse at N+2, wb_data=0, regfile[3]=0.
REQ-032 Preload r1=5, r2=7 (via ops), then back-to-back: r3=r1+r2 then r4=r3-r1 -> second op's alu_a=12 via forwarding, wb_data sequence 12 then 7.
REQ-033 Write rd=0 with result 0xFFFF_FFFF -> wb_valid=1, wb_data=0xFFFF_FFFF, later read of r0 gives 0.
REQ-034 ALU add 0xFFFF_FFFF+1 with alu_carry=1 -> carry_flag=1 at N+2; next op with carry 0 clears it.
REQ-035 Assert stall for 3 cycles with op in EX -> req_ready=0, alu_a/alu_b/wb outputs unchanged; writeback completes 1 cycle after stall drops.
REQ-036 Drop rst_n asynchronously while op in EX -> all outputs 0 immediately; no wb_valid after release, destination register reads 0.
